// File: rtl/sram_pkg.sv
// Shared helpers for the 1R1W masked SRAM family.
// Holds the read-latency legality check and the lane merge.
package sram_pkg;

    localparam int MAX_W = 256;

    typedef logic [MAX_W-1:0] wide_t;

    function automatic bit latency_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

    // Bit b belongs to lane b/lw; masked lanes take the new word.
    function automatic wide_t lane_merge(
        input wide_t old_word,
        input wide_t new_word,
        input wide_t mask,
        input int    lw
    );
        wide_t      r;
        logic [7:0] li;
        for (int b = 0; b < MAX_W; b++) begin
            li   = 8'(b / lw);
            r[b] = mask[li] ? new_word[b] : old_word[b];
        end
        return r;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-result pipeline of depth 1 or 2 carrying {data, valid, strobe}.
// Data and valid only advance alongside a strobe, so idle cycles hold.
module sram_rd_pipe #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strobe,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             strobe_q,
    output logic [WIDTH-1:0] data_q,
    output logic             valid_q
);

    logic [WIDTH-1:0] d_r [DEPTH];
    logic [DEPTH-1:0] v_r;
    logic [DEPTH-1:0] s_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) d_r[k] <= '0;
            v_r <= '0;
            s_r <= '0;
        end else begin
            s_r[0] <= strobe;
            if (strobe) begin
                d_r[0] <= data;
                v_r[0] <= valid;
            end
            for (int k = 1; k < DEPTH; k++) begin
                s_r[k] <= s_r[k-1];
                if (s_r[k-1]) begin
                    d_r[k] <= d_r[k-1];
                    v_r[k] <= v_r[k-1];
                end
            end
        end
    end

    assign strobe_q = s_r[DEPTH-1];
    assign data_q   = d_r[DEPTH-1];
    assign valid_q  = v_r[DEPTH-1];

endmodule

// File: rtl/sram_1r1w_mask_bypass.sv
// 1W/1R SRAM with lane write mask, per-entry valid bits, flash
// invalidate and optional same-edge write-to-read forwarding.
module sram_1r1w_mask_bypass
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH   = 19,
    parameter int ADDR_WIDTH   = 8,
    parameter int LANES        = 1,
    parameter int READ_LATENCY = 1,
    parameter int BYPASS       = 1
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  csb0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic [LANES-1:0]      wmask0,
    input  logic                  inv0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dout1_valid,
    output logic                  rvalid1
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int LW        = DATA_WIDTH / LANES;

    if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end

    if ((DATA_WIDTH % LANES) != 0 || DATA_WIDTH > MAX_W) begin : g_bad_lanes
        $error("DATA_WIDTH must divide evenly by LANES");
    end

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_DEPTH-1:0]  valid;

    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_valid;
    logic                  wr_en;
    logic                  rd_en;
    logic                  hit;

    assign wr_en = !rst0 && !csb0 && (|wmask0);
    assign rd_en = !csb1;
    assign hit   = wr_en && (addr0 == addr1);

    assign wr_word = DATA_WIDTH'(lane_merge(wide_t'(mem[addr0]),
                                            wide_t'(din0),
                                            wide_t'(wmask0), LW));

    always_ff @(posedge clk0) begin
        if (wr_en) mem[addr0] <= wr_word;
    end

    // Invalidate first, then the write sets its own entry.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            valid <= '0;
        end else begin
            if (inv0) valid <= '0;
            if (wr_en) valid[addr0] <= 1'b1;
        end
    end

    // With forwarding the read sees the post-edge state.
    always_comb begin
        rd_word  = mem[addr1];
        rd_valid = valid[addr1];
        if (BYPASS != 0) begin
            if (inv0) rd_valid = 1'b0;
            if (hit) begin
                rd_word  = wr_word;
                rd_valid = 1'b1;
            end
        end
    end

    sram_rd_pipe #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (READ_LATENCY)
    ) u_rd_pipe (
        .clk      (clk0),
        .rst      (rst0),
        .strobe   (rd_en),
        .data     (rd_word),
        .valid    (rd_valid),
        .strobe_q (rvalid1),
        .data_q   (dout1),
        .valid_q  (dout1_valid)
    );

endmodule
